sevenseg_scan: RTL and testbench
================================

// Module: sevenseg_scan
// PURPOSE
//  Time-multiplexed scanner for a DIGITS-wide common-bus 7-segment display.
//  Holds one BCD nibble per digit and presents one 4-bit code per scan slot to
//  the downstream BCD-to-segment decoder (codes 0-9 only).
//  Drives a one-hot digit enable with an anti-ghosting guard between slots.
//  New values are accepted through a valid/ready load port and applied only at
//  frame boundaries, so a frame never shows a mix of old and new digits.
// PARAMETERS
//  DIGITS  4   number of digits; legal range 2..8
//  DIV     1000  clocks per scan slot; must be >= GUARD+2
//  GUARD   2   clocks at slot start with all digits off; range 0..DIV-2
// PORTS
//  clk         in   1          single clock, all logic rising-edge
//  rst_n       in   1          synchronous, active-low reset
//  load_valid  in   1          load request
//  load_ready  out  1          pending buffer empty; load accepted when valid&ready
//  load_data   in   4*DIGITS   BCD digits; [3:0] is digit 0 (least significant)
//  blank_lz    in   1          1 = blank leading zeros; digit 0 is never blanked
//  digit_code  out  4          BCD code to the segment decoder; always 0..9
//  digit_en    out  DIGITS     one-hot active-high digit enable, or all zero
//  bcd_err     out  1          sticky: a committed nibble was > 9
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//  - cnt=0, idx=0, disp=0, pending empty
//  - digit_code=0, digit_en=0, bcd_err=0, load_ready=1
//  - a pending load is discarded
//  Prescaler and index:
//  - cnt runs 0..DIV-1; at cnt==DIV-1, cnt wraps to 0 and idx advances
//  - idx wraps DIGITS-1 -> 0; this edge is the frame boundary
//  - frame length = DIGITS*DIV clocks
//  Load handshake:
//  - load_ready = !pending_full (combinational from the register)
//  - valid&ready captures load_data into pending; load_data need not be held after
//  - pending commits to disp at the frame-boundary edge and clears the same edge
//  - there is no bypass: a load accepted in the boundary cycle commits at the next boundary
//  - valid while ready=0: nothing is captured; the source holds until ready
//  Outputs (registered, one-clock lag behind cnt/idx):
//  - digit_en = onehot(idx) when cnt >= GUARD and the digit is not blanked
//  - otherwise digit_en = 0
//  - digit_code = disp[idx] when that digit is enabled; otherwise 0
//  Blanking:
//  - nibble > 9: the digit is blanked and bcd_err is set at commit; it stays set until reset
//  - blank_lz=1: digit i>0 is blanked if it and every higher digit are 0
//  - blank_lz is sampled live every cycle, not latched at commit
//  - the decoder therefore never sees codes 10-15
// STRUCTURE
//  Package sevenseg_pkg:
//  - BCD_W=4, BCD_MAX=9
//  - function onehot(idx)
//  - function lz_mask(disp) returning the leading-zero blank vector
//  Sub-module sevenseg_prescaler (DIV): outputs cnt and slot_end tick.
//  Everything else is inline.
// TESTING (DIGITS=4, DIV=8, GUARD=2)
//  1. Reset: rst_n=0 for 3 clks -> digit_en=0, digit_code=0, load_ready=1, bcd_err=0
//  2. Load 16'h1234; after the next boundary -> slot0 code 4 en 0001, slot1 3/0010, slot2 2/0100, slot3 1/1000
//     - each enable is high 6 of 8 clks; frame = 32 clks
//  3. blank_lz=1, load 16'h0050 -> slots 3,2 en=0; slot1 code 5 en 0010; slot0 code 0 en 0001
//  4. Two back-to-back loads (AAAA-free 16'h1111, then 16'h2222):
//     - ready=0 after the first until its commit
//     - no frame ever mixes 1s and 2s
//  5. Load 16'h00A1 -> digit1 en=0 and code 0 in its slot; bcd_err=1 and stays 1 after load 16'h0000
//  6. rst_n=0 mid-slot with a load pending -> next edge gives the full reset state
//     - pending is dropped; display stays 0 after release

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
package sevenseg_pkg;

    localparam int BCD_W      = 4;
    localparam int BCD_MAX    = 9;
    localparam int MAX_DIGITS = 8;
    localparam int MAX_DW     = MAX_DIGITS * BCD_W;

    // One-hot decode of a digit index; callers truncate to their digit count.
    function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Bit i is set when digit i (i > 0) and every digit above it, up to
    // 'digits', are zero. Digit 0 is never reported as a leading zero so a
    // value of all zeros still shows a single "0".
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [MAX_DW-1:0] disp,
        input int                digits
    );
        logic all_zero;
        lz_mask  = '0;
        all_zero = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (i < digits) begin
                all_zero   = all_zero && (disp[i*BCD_W +: BCD_W] == '0);
                lz_mask[i] = all_zero && (i != 0);
            end
        end
    endfunction

endpackage

// File: rtl/sevenseg_prescaler.sv
// Slot prescaler: counts 0..DIV-1 and flags the last clock of each slot.
module sevenseg_prescaler #(
    parameter int DIV = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [$clog2(DIV)-1:0] cnt_o,
    output logic                   slot_end_o
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign slot_end_o = (cnt_q == CW'(DIV - 1));
    assign cnt_o      = cnt_q;
    assign cnt_d      = slot_end_o ? '0 : cnt_q + CW'(1);

    // Free-running slot counter with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed BCD scanner for a common-bus 7-segment display.
// Loads land in a one-entry pending buffer and are committed to the
// displayed value only on the frame boundary, so a frame is never torn.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 1000,
    parameter int GUARD  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*DIGITS-1:0]     load_data,
    input  logic                    blank_lz,
    output logic [3:0]              digit_code,
    output logic [DIGITS-1:0]       digit_en,
    output logic                    bcd_err
);

    localparam int DW = DIGITS * BCD_W;
    localparam int CW = $clog2(DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Prescaler outputs
    logic [CW-1:0]       cnt;
    logic                slot_end;

    // Registered state
    logic [IW-1:0]       idx_q,       idx_d;
    logic [DW-1:0]       disp_q,      disp_d;
    logic [DW-1:0]       pend_q,      pend_d;
    logic                pend_full_q, pend_full_d;
    logic                bcd_err_q,   bcd_err_d;
    logic [BCD_W-1:0]    code_q,      code_d;
    logic [DIGITS-1:0]   en_q,        en_d;

    // Decode helpers
    logic                frame_end;
    logic                accept;
    logic                pend_bad;
    logic                slot_on;
    logic [DIGITS-1:0]   blank_vec;
    logic [BCD_W-1:0]    cur_nib;
    logic                cur_blank;

    sevenseg_prescaler #(
        .DIV        (DIV)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_o      (cnt),
        .slot_end_o (slot_end)
    );

    assign frame_end  = slot_end && (idx_q == IW'(DIGITS - 1));
    assign accept     = load_valid && !pend_full_q;
    assign slot_on    = (cnt >= CW'(GUARD));

    assign load_ready = !pend_full_q;
    assign digit_code = code_q;
    assign digit_en   = en_q;
    assign bcd_err    = bcd_err_q;

    // Blanking vector and the nibble/blank state of the digit in the current slot.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        pend_bad  = 1'b0;
        blank_vec = blank_lz ? DIGITS'(lz_mask(MAX_DW'(disp_q), DIGITS)) : '0;
        cur_nib   = '0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (pend_q[i*BCD_W +: BCD_W] > BCD_W'(BCD_MAX)) begin
                pend_bad = 1'b1;
            end
            if (disp_q[i*BCD_W +: BCD_W] > BCD_W'(BCD_MAX)) begin
                blank_vec[i] = 1'b1;
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib   = disp_q[i*BCD_W +: BCD_W];
                cur_blank = blank_vec[i];
            end
        end
    end

    // Next-state: slot index, pending/commit path, sticky error, outputs.
    always_comb begin
        idx_d       = idx_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        bcd_err_d   = bcd_err_q;

        if (slot_end) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end

        // Commit and capture are mutually exclusive: capture needs an empty
        // buffer, commit needs a full one. A load taken in the boundary
        // cycle therefore waits a full frame.
        if (frame_end && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
            bcd_err_d   = bcd_err_q | pend_bad;
        end
        if (accept) begin
            pend_d      = load_data;
            pend_full_d = 1'b1;
        end

        // Outputs lag cnt/idx by one clock since they are registered here.
        en_d   = (slot_on && !cur_blank) ? DIGITS'(onehot(3'(idx_q))) : '0;
        code_d = (en_d != '0) ? cur_nib : '0;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q       <= '0;
            disp_q      <= '0;
            // NOTE: pend_q is cleared too even though pend_full_q alone gates
            // its use; it costs nothing and keeps X out of pend_bad.
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            bcd_err_q   <= 1'b0;
            code_q      <= '0;
            en_q        <= '0;
        end else begin
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            bcd_err_q   <= bcd_err_d;
            code_q      <= code_d;
            en_q        <= en_d;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan: a reference model predicts every
// registered output per clock, a monitor pops and compares.
module tb_sevenseg_scan;

    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int GUARD  = 2;
    localparam int FRAME  = DIGITS * DIV;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 load_valid = 1'b0;
    logic                 load_ready;
    logic [4*DIGITS-1:0]  load_data = '0;
    logic                 blank_lz = 1'b0;
    logic [3:0]           digit_code;
    logic [DIGITS-1:0]    digit_en;
    logic                 bcd_err;

    sevenseg_scan #(
        .DIGITS     (DIGITS),
        .DIV        (DIV),
        .GUARD      (GUARD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .blank_lz   (blank_lz),
        .digit_code (digit_code),
        .digit_en   (digit_en),
        .bcd_err    (bcd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]        code;
        logic [DIGITS-1:0] en;
        logic              err;
        logic              ready;
        bit                frame_start;
        bit                is_rst;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mix_watch = 1'b0;

    // Reference model state: clocks since reset, shown digits, pending load.
    int   tick = 0;
    int   shown[DIGITS];
    int   pend_val[DIGITS];
    bit   pend_full = 1'b0;
    bit   err_flag = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_blank(input int i);
        if (shown[i] > 9) return 1'b1;
        if (!blank_lz || i == 0) return 1'b0;
        for (int j = i; j < DIGITS; j++) begin
            if (shown[j] != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference model: one expectation per rising edge.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            e.frame_start = 1'b0;
            e.is_rst      = 1'b0;
            if (!rst_n) begin
                tick      = 0;
                pend_full = 1'b0;
                err_flag  = 1'b0;
                for (int i = 0; i < DIGITS; i++) shown[i] = 0;
                e.code   = '0;
                e.en     = '0;
                e.err    = 1'b0;
                e.ready  = 1'b1;
                e.is_rst = 1'b1;
            end else begin
                int  cnt, idx;
                bit  was_full;
                cnt = tick % DIV;
                idx = (tick / DIV) % DIGITS;
                e.en          = (cnt >= GUARD && !is_blank(idx)) ? DIGITS'(1 << idx) : '0;
                e.code        = (e.en != '0) ? 4'(shown[idx]) : 4'd0;
                e.frame_start = (tick % FRAME == 0);
                was_full      = pend_full;
                if ((tick % FRAME == FRAME - 1) && was_full) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        shown[i] = pend_val[i];
                        if (pend_val[i] > 9) err_flag = 1'b1;
                    end
                    pend_full = 1'b0;
                end
                if (load_valid && !was_full) begin
                    for (int i = 0; i < DIGITS; i++) pend_val[i] = int'(load_data[i*4 +: 4]);
                    pend_full = 1'b1;
                end
                tick++;
                e.err   = err_flag;
                e.ready = !pend_full;
            end
            sb.push_back(e);
        end
    end

    // Monitor: compares DUT outputs shortly after each edge.
    initial begin
        bit seen1 = 1'b0;
        bit seen2 = 1'b0;
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("digit_code", 32'(digit_code), 32'(e.code));
                check("digit_en",   32'(digit_en),   32'(e.en));
                check("bcd_err",    32'(bcd_err),    32'(e.err));
                check("load_ready", 32'(load_ready), 32'(e.ready));
                if (e.is_rst) begin
                    seen1 = 1'b0;
                    seen2 = 1'b0;
                end else begin
                    if (e.frame_start) begin
                        if (mix_watch && (seen1 || seen2)) begin
                            check("frame_mix", 32'(seen1 && seen2), 32'd0);
                        end
                        seen1 = 1'b0;
                        seen2 = 1'b0;
                    end
                    if (digit_en != '0 && digit_code == 4'd1) seen1 = 1'b1;
                    if (digit_en != '0 && digit_code == 4'd2) seen2 = 1'b1;
                end
            end
        end
    end

    // Present one load and hold it until accepted; data is scrambled after.
    task automatic do_load(input logic [4*DIGITS-1:0] d);
        int budget = 4 * FRAME;
        @(negedge clk);
        load_data  = d;
        load_valid = 1'b1;
        while (!load_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("load_timeout", 32'd1, 32'd0);
        @(negedge clk);
        load_valid = 1'b0;
        load_data  = 16'($urandom);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
        end
    endtask

    function automatic logic [4*DIGITS-1:0] rand_value();
        logic [4*DIGITS-1:0] v = '0;
        int nd = $urandom_range(1, DIGITS);
        for (int i = 0; i < nd; i++) begin
            if ($urandom_range(0, 11) == 0) v[i*4 +: 4] = 4'($urandom_range(10, 15));
            else                            v[i*4 +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    initial begin
        // Reset held for three clocks.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Plain digits.
        do_load(16'h1234);
        repeat (2 * FRAME) @(negedge clk);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        do_load(16'h0050);
        repeat (2 * FRAME) @(negedge clk);

        // Back-to-back loads: frames must be all-1 or all-2.
        blank_lz  = 1'b0;
        mix_watch = 1'b1;
        do_load(16'h1111);
        do_load(16'h2222);
        repeat (3 * FRAME) @(negedge clk);
        mix_watch = 1'b0;

        // Invalid nibble: blanked digit and sticky error.
        do_load(16'h00A1);
        repeat (2 * FRAME) @(negedge clk);
        do_load(16'h0000);
        repeat (2 * FRAME) @(negedge clk);

        // Random loads with live blank_lz toggling.
        repeat (30) begin
            blank_lz = 1'($urandom_range(0, 1));
            do_load(rand_value());
            idle($urandom_range(0, 40));
        end

        // Reset mid-slot with a load pending.
        blank_lz = 1'b0;
        repeat (2 * FRAME) @(negedge clk);
        begin
            int budget = 2 * FRAME;
            while ((tick % FRAME) != 4 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (budget == 0) check("sync_timeout", 32'd1, 32'd0);
        end
        do_load(16'h9876);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * FRAME) @(negedge clk);

        // A few random loads after reset.
        repeat (6) begin
            blank_lz = 1'($urandom_range(0, 1));
            do_load(rand_value());
            idle($urandom_range(FRAME, 2 * FRAME));
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
